cam_readout: RTL and testbench

- Reader side of the fault-collection CAM.
- On `start`, snapshots the flattened pivot and non-pivot CAM arrays.
- Emits a valid/ready record stream to the redundancy-analysis solver, in tree order: each enabled pivot entry, followed immediately by every enabled non-pivot entry whose pointer names that pivot.
- Sits between the fault CAM and the repair-solution search logic.

---
 rtl/cam_readout.sv | 184 ++++++++++++++++++
 tb/tb_cam_readout.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_readout.sv
// Fault-CAM reader: snapshots pivot/non-pivot arrays on start and streams them in tree order.
// Optional CAM_RD_MUST_SKIP_EN: must-repair pivots suppress their non-pivot children.
module cam_readout #(
    parameter int PCAM  = 8,
    parameter int NPCAM = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  early_term,
    input  logic                  start,
    input  logic [PCAM*26-1:0]    pivot_in,
    input  logic [NPCAM*17-1:0]   npivot_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_kind,
    output logic [2:0]            out_pidx,
    output logic [4:0]            out_nidx,
    output logic [25:0]           out_entry,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            pivot_cnt,
    output logic [5:0]            npivot_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_PIV, S_NP, S_DONE} state_t;

    localparam logic [3:0] P_END = 4'(PCAM);
    localparam logic [5:0] N_END = 6'(NPCAM);

    state_t                       state_q, state_d;
    logic [3:0]                   p_q, p_d;
    logic [5:0]                   n_q, n_d;
    logic [PCAM-1:0][25:0]        piv_q;
    logic [NPCAM-1:0][16:0]       np_q;

    logic                         out_valid_q;
    logic                         out_kind_q;
    logic [2:0]                   out_pidx_q;
    logic [4:0]                   out_nidx_q;
    logic [25:0]                  out_entry_q;
    logic [3:0]                   pcnt_q;
    logic [5:0]                   ncnt_q;

    logic [2:0]                   pi;
    logic [4:0]                   ni;
    logic [25:0]                  cur_piv;
    logic [16:0]                  cur_np;
    logic                         hs;
    logic                         slot_free;
    logic                         capture;
    logic                         load;
    logic                         ld_kind;
    logic [4:0]                   ld_nidx;
    logic [25:0]                  ld_entry;

    assign pi        = p_q[2:0];
    assign ni        = n_q[4:0];
    assign cur_piv   = piv_q[pi];
    assign cur_np    = (n_q < N_END) ? np_q[ni] : '0;
    assign hs        = out_valid_q & out_ready;
    // The output register acts as a one-deep buffer: the scan may refill it
    // on the same edge it is drained, giving one record per cycle.
    assign slot_free = ~out_valid_q | out_ready;

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        n_d      = n_q;
        capture  = 1'b0;
        load     = 1'b0;
        ld_kind  = 1'b0;
        ld_nidx  = '0;
        ld_entry = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    p_d     = '0;
                    n_d     = '0;
                    state_d = S_PIV;
                end
            end
            S_PIV: begin
                if (p_q == P_END) begin
                    // Hold off the done pulse until the final record is accepted.
                    if (slot_free) state_d = S_DONE;
                end else if (!cur_piv[25]) begin
                    p_d = p_q + 4'd1;
                end else if (slot_free) begin
                    load     = 1'b1;
                    ld_entry = cur_piv;
`ifdef CAM_RD_MUST_SKIP_EN
                    if (cur_piv[2:0] != 3'd0) begin
                        p_d = p_q + 4'd1;
                    end else begin
                        n_d     = '0;
                        state_d = S_NP;
                    end
`else
                    n_d     = '0;
                    state_d = S_NP;
`endif
                end
            end
            S_NP: begin
                if (n_q == N_END) begin
                    p_d     = p_q + 4'd1;
                    state_d = S_PIV;
                end else if (cur_np[16] && (cur_np[15:13] == pi)) begin
                    if (slot_free) begin
                        load     = 1'b1;
                        ld_kind  = 1'b1;
                        ld_nidx  = ni;
                        ld_entry = {9'd0, cur_np};
                        n_d      = n_q + 6'd1;
                    end
                end else begin
                    n_d = n_q + 6'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (early_term) begin
            state_d = S_IDLE;
            capture = 1'b0;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            n_q         <= '0;
            piv_q       <= '0;
            np_q        <= '0;
            out_valid_q <= 1'b0;
            out_kind_q  <= 1'b0;
            out_pidx_q  <= '0;
            out_nidx_q  <= '0;
            out_entry_q <= '0;
            pcnt_q      <= '0;
            ncnt_q      <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            n_q     <= n_d;
            if (capture) begin
                piv_q <= pivot_in;
                np_q  <= npivot_in;
            end
            if (early_term) begin
                out_valid_q <= 1'b0;
            end else if (load) begin
                out_valid_q <= 1'b1;
                out_kind_q  <= ld_kind;
                out_pidx_q  <= pi;
                out_nidx_q  <= ld_nidx;
                out_entry_q <= ld_entry;
            end else if (hs) begin
                out_valid_q <= 1'b0;
            end
            if (capture) begin
                pcnt_q <= '0;
                ncnt_q <= '0;
            end else if (hs && !early_term) begin
                if (out_kind_q) ncnt_q <= ncnt_q + 6'd1;
                else            pcnt_q <= pcnt_q + 4'd1;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_kind   = out_kind_q;
    assign out_pidx   = out_pidx_q;
    assign out_nidx   = out_nidx_q;
    assign out_entry  = out_entry_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign pivot_cnt  = pcnt_q;
    assign npivot_cnt = ncnt_q;

endmodule

// File: tb/tb_cam_readout.sv
// Bench for cam_readout: directed and random CAM loads checked against a tree-order model.
module tb_cam_readout;
    localparam int PCAM  = 8;
    localparam int NPCAM = 30;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 early_term = 1'b0;
    logic                 start = 1'b0;
    logic                 out_ready = 1'b0;
    logic [PCAM*26-1:0]   pivot_in = '0;
    logic [NPCAM*17-1:0]  npivot_in = '0;
    logic                 out_valid, out_kind, busy, done;
    logic [2:0]           out_pidx;
    logic [4:0]           out_nidx;
    logic [25:0]          out_entry;
    logic [3:0]           pivot_cnt;
    logic [5:0]           npivot_cnt;

    int checks = 0;
    int failures = 0;

    logic [25:0] piv [PCAM];
    logic [16:0] np  [NPCAM];
    logic [34:0] expq [$];
    int          exp_p, exp_n;
    int          first_v, done_at;

    cam_readout #(.PCAM(PCAM), .NPCAM(NPCAM)) dut (
        .clk(clk), .rst(rst), .early_term(early_term), .start(start),
        .pivot_in(pivot_in), .npivot_in(npivot_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_pidx(out_pidx), .out_nidx(out_nidx), .out_entry(out_entry),
        .busy(busy), .done(done), .pivot_cnt(pivot_cnt), .npivot_cnt(npivot_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void clear_load();
        for (int i = 0; i < PCAM; i++)  piv[i] = '0;
        for (int j = 0; j < NPCAM; j++) np[j]  = '0;
    endfunction

    function automatic logic [25:0] mk_piv(input logic [9:0] row, input logic [9:0] col,
                                           input logic [1:0] bank, input logic [2:0] must);
        return {1'b1, row, col, bank, must};
    endfunction

    function automatic logic [16:0] mk_np(input logic [2:0] ptr, input logic [9:0] addr);
        return {1'b1, ptr, 1'b0, addr, 2'd1};
    endfunction

    // Drive the CAM image and derive the expected record stream from the tree-order rules.
    task automatic apply_load();
        for (int i = 0; i < PCAM; i++)  pivot_in[26*i +: 26] = piv[i];
        for (int j = 0; j < NPCAM; j++) npivot_in[17*j +: 17] = np[j];
        expq.delete();
        exp_p = 0;
        exp_n = 0;
        for (int p = 0; p < PCAM; p++) begin
            if (!piv[p][25]) continue;
            expq.push_back({1'b0, 3'(p), 5'd0, piv[p]});
            exp_p++;
`ifdef CAM_RD_MUST_SKIP_EN
            if (piv[p][2:0] != 3'd0) continue;
`endif
            for (int n = 0; n < NPCAM; n++) begin
                if (np[n][16] && np[n][15:13] == 3'(p)) begin
                    expq.push_back({1'b1, 3'(p), 5'(n), 9'd0, np[n]});
                    exp_n++;
                end
            end
        end
    endtask

    // rmode: 0 ready high, 1 one-on/two-off, 2 random. abort_after >= 0 ends the
    // scan with early_term once that many records were accepted and the next one stalls.
    task automatic run_scan(input string tag, input int rmode, input int abort_after,
                            input bit disturb);
        int          k, got, cp, cn;
        bit          stalled, aborted;
        logic [34:0] cur, prev, e;
        first_v = -1;
        done_at = -1;
        got = 0; cp = 0; cn = 0;
        stalled = 0; aborted = 0;
        prev = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (k < 2000) begin
            cur = {out_kind, out_pidx, out_nidx, out_entry};
            if (out_valid && first_v < 0) first_v = k;
            if (stalled) check({tag, " stall_hold"}, {out_valid, cur}, {1'b1, prev});
            if (done) begin
                done_at = k;
                break;
            end
            if (abort_after >= 0 && got == abort_after) begin
                int w;
                out_ready = 1'b0;
                w = 0;
                while (!out_valid && w < 60) begin
                    @(posedge clk); #1;
                    w++;
                end
                @(posedge clk); #1;
                check({tag, " stalled_valid"}, out_valid, 1);
                early_term = 1'b1;
                @(posedge clk); #1;
                early_term = 1'b0;
                check({tag, " abort_valid"}, out_valid, 0);
                check({tag, " abort_busy"}, busy, 0);
                check({tag, " abort_done"}, done, 0);
                check({tag, " abort_pcnt"}, pivot_cnt, cp);
                check({tag, " abort_ncnt"}, npivot_cnt, cn);
                repeat (3) @(posedge clk);
                #1;
                check({tag, " abort_idle_done"}, {busy, done}, 0);
                aborted = 1;
                break;
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                e = (expq.size() > 0) ? expq.pop_front() : '0;
                if (e[34]) cn++; else cp++;
                check({tag, " record"}, cur, e);
                got++;
                stalled = 0;
            end else begin
                stalled = out_valid;
            end
            prev = cur;
            if (disturb && k == 3) begin
                for (int i = 0; i < PCAM; i++) pivot_in[26*i +: 26] = 26'($urandom);
                start = 1'b1;
            end else if (disturb && k == 4) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        if (!aborted) begin
            check({tag, " done_seen"}, (done_at >= 0), 1);
            check({tag, " leftover"}, expq.size(), 0);
            check({tag, " pivot_cnt"}, pivot_cnt, exp_p);
            check({tag, " npivot_cnt"}, npivot_cnt, exp_n);
            @(posedge clk); #1;
            check({tag, " done_pulse_end"}, {busy, done}, 0);
        end
    endtask

    initial begin
        clear_load();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {out_valid, busy, done, pivot_cnt, npivot_cnt, out_entry}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_outs", {out_valid, busy, done, out_kind, out_pidx, out_nidx}, 0);

        // Single pivot, no children.
        clear_load();
        piv[0] = {1'b1, 10'h005, 10'h007, 2'd1, 3'd0};
        apply_load();
        run_scan("p0_only", 0, -1, 0);
        check("p0_only latency", first_v, 1);

        // Small tree, ready high, then with one-on/two-off ready.
        clear_load();
        piv[0] = mk_piv(10'h011, 10'h022, 2'd0, 3'd0);
        piv[2] = mk_piv(10'h133, 10'h244, 2'd2, 3'd0);
        np[4]  = mk_np(3'd2, 10'h3A4);
        np[1]  = mk_np(3'd0, 10'h101);
        np[9]  = mk_np(3'd0, 10'h109);
        np[7]  = mk_np(3'd5, 10'h107);
        apply_load();
        run_scan("tree", 0, -1, 0);
        apply_load();
        run_scan("tree_stall", 1, -1, 0);

        // Live inputs and a second start during the scan must not matter.
        apply_load();
        run_scan("tree_disturb", 0, -1, 1);

        // Abort while a record is stalled, then a fresh start replays from P0.
        apply_load();
        run_scan("tree_abort", 0, 2, 0);
        apply_load();
        run_scan("tree_replay", 0, -1, 0);

        // Empty CAM.
        clear_load();
        np[3] = {1'b0, 3'd0, 1'b0, 10'h3FF, 2'd3};
        apply_load();
        run_scan("empty", 0, -1, 0);
        check("empty no_valid", first_v, -1);
        check("empty done_at", done_at, PCAM + 1);

        // Skipped pivots add one cycle each to first-record latency.
        clear_load();
        piv[2] = mk_piv(10'h3FF, 10'h000, 2'd3, 3'd0);
        apply_load();
        run_scan("skip2", 0, -1, 0);
        check("skip2 latency", first_v, 3);

        // Must-repair pivot with children.
        clear_load();
        piv[0] = mk_piv(10'h0AA, 10'h055, 2'd1, 3'b100);
        np[0]  = mk_np(3'd0, 10'h200);
        np[1]  = mk_np(3'd0, 10'h201);
        apply_load();
        run_scan("must", 0, -1, 0);
        check("must exp_n", npivot_cnt,
`ifdef CAM_RD_MUST_SKIP_EN
              0
`else
              2
`endif
        );

        // Random loads with random backpressure.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < PCAM; i++)
                piv[i] = {1'($urandom_range(0, 1)), 25'($urandom)};
            for (int j = 0; j < NPCAM; j++)
                np[j] = {1'($urandom_range(0, 2) == 0 ? 0 : 1), 3'($urandom_range(0, 7)), 13'($urandom)};
            apply_load();
            run_scan("random", 2, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
